// File: rtl/bp_pht_update_sched.sv
// bp_pht_update_sched: single write-port scheduler for a 2-bit counter PHT.
// Reset sweep to INIT_STATE, then FIFO-queued read-modify-write updates.
// Optional macro BP_UPD_DROP_CNT_EN builds the saturating drop counter.
module bp_pht_update_sched #(
    parameter int         PHT_DEPTH  = 7,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 upd_valid,
    input  logic [PHT_DEPTH-1:0] upd_index,
    input  logic                 upd_taken,
    output logic                 upd_ready,
    output logic [PHT_DEPTH-1:0] pht_raddr,
    input  logic [1:0]           pht_rdata,
    output logic                 pht_we,
    output logic [PHT_DEPTH-1:0] pht_waddr,
    output logic [1:0]           pht_wdata,
    output logic                 init_busy,
    output logic [15:0]          drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam logic [PHT_DEPTH-1:0] LAST = {PHT_DEPTH{1'b1}};
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    logic [0:0]           state;
    logic [PHT_DEPTH-1:0] sweep_ptr;
    logic [PHT_DEPTH-1:0] fifo_idx [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_tk;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [PHT_DEPTH-1:0] last_raddr;
    logic [PHT_DEPTH-1:0] head_idx;
    logic                 head_tk;
    logic                 in_init;
    logic                 not_empty;
    logic                 push;
    logic                 pop;
    logic [1:0]           sat_data;

    assign head_idx  = fifo_idx[rd_ptr];
    assign head_tk   = fifo_tk[rd_ptr];
    assign in_init   = (state == S_INIT);
    assign not_empty = (count != '0);
    assign upd_ready = (count != FULL);
    assign push      = upd_valid && upd_ready;
    assign pop       = !rst && !in_init && not_empty;

    assign init_busy = in_init || rst;
    assign pht_raddr = not_empty ? head_idx : last_raddr;
    assign pht_we    = !rst && (in_init || not_empty);
    assign pht_waddr = in_init ? sweep_ptr : head_idx;
    assign pht_wdata = in_init ? INIT_STATE : sat_data;

    // saturating +1 / -1 of the counter read at the head index
    always_comb begin
        sat_data = pht_rdata;
        if (head_tk) begin
            if (pht_rdata != 2'b11) sat_data = pht_rdata + 2'd1;
        end else begin
            if (pht_rdata != 2'b00) sat_data = pht_rdata - 2'd1;
        end
    end

    // sweep FSM: walk every PHT entry once, then hand the port to the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            sweep_ptr <= '0;
        end else if (in_init) begin
            sweep_ptr <= sweep_ptr + PHT_DEPTH'(1);
            if (sweep_ptr == LAST) state <= S_RUN;
        end
    end

    // queue pointers and occupancy; reset discards anything pending
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_raddr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                last_raddr <= head_idx;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // queue payload storage, written at the tail
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_idx[wr_ptr] <= upd_index;
            fifo_tk[wr_ptr]  <= upd_taken;
        end
    end

`ifdef BP_UPD_DROP_CNT_EN
    logic [15:0] drop_q;

    // saturating count of pushes refused by a full queue
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (upd_valid && !upd_ready && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: doc/bp_pht_update_sched.md
# bp_pht_update_sched

Scheduler for the single write port of a branch-predictor pattern history table (PHT) of 2-bit saturating counters. After reset it sweeps the whole table to a known counter state. It then retires resolved-branch updates from the Memory stage through a small FIFO, one per cycle, using read-modify-write on the addressed counter. It sits between the M-stage branch resolution and the PHT storage owned by the global/local predictors, and tells the front end when table contents are not yet valid.

## Interface
Parameters:
- PHT_DEPTH, 7, PHT index width; table has 2^PHT_DEPTH entries
- FIFO_DEPTH, 4, update queue entries; power of two, ≥2
- INIT_STATE, 2'b01, counter value written by the reset sweep (weakly not-taken)

Ports:
- Reset is synchronous and active-high.
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- upd_valid  in  1  M-stage resolved branch (branchM)
- upd_index  in  PHT_DEPTH  PHT index used at prediction time
- upd_taken  in  1  actual outcome (pcsrcM)
- upd_ready  out  1  queue can accept this cycle (= !full)
- pht_raddr  out  PHT_DEPTH  read address for RMW; equals FIFO head index
- pht_rdata  in  2  combinational read of PHT[pht_raddr]
- pht_we  out  1  PHT write enable
- pht_waddr  out  PHT_DEPTH  PHT write address
- pht_wdata  out  2  PHT write data
- init_busy  out  1  high while the reset sweep runs; predictions invalid
- drop_cnt  out  16  count of updates lost to a full queue (see Configuration)

## Operation
- FSM states: INIT, RUN. Reset enters INIT with sweep pointer 0, FIFO empty, drop_cnt 0.
- INIT: each cycle pht_we=1, pht_waddr=pointer, pht_wdata=INIT_STATE; pointer increments. The cycle writing address 2^PHT_DEPTH-1 is the last INIT cycle; the FSM moves to RUN next. The queue is not drained in INIT.
- The FIFO accepts pushes in both states when upd_valid && upd_ready. A push while full (upd_valid && !upd_ready) is dropped, and drop_cnt increments when the macro is enabled.
- RUN with FIFO non-empty: pht_raddr=head.index, pht_we=1, pht_waddr=head.index. pht_wdata is the saturating update of pht_rdata: taken → min(rdata+1, 3), not-taken → max(rdata-1, 0). The head pops at the edge.
- RUN with FIFO empty: pht_we=0. pht_waddr and pht_wdata are don't-care; pht_raddr holds its last value.
- Push and pop in the same cycle leave the occupancy unchanged. Order is strict FIFO.
- Back-to-back updates to the same index are correct without forwarding, because each write lands at the edge before the next read.
- Occupancy uses log2(FIFO_DEPTH)+1 bits. Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: init_busy=1, pht_we=0 during the reset cycle, upd_ready=1, drop_cnt=0.
- The sweep takes exactly 2^PHT_DEPTH cycles after rst deasserts. init_busy falls in the first RUN cycle.
- Update latency: an update pushed in cycle t, with the queue empty and in RUN, is written at the edge ending cycle t+1.
- upd_ready depends only on registered occupancy, with no combinational path from upd_valid. When full, upd_ready=0 even in a cycle that pops.
- Throughput: one retired update per cycle in RUN.
- rst asserted mid-operation (INIT or RUN) discards queued updates with no further PHT writes, then restarts the sweep at address 0 on the next cycle.

## Configuration
- BP_UPD_DROP_CNT_EN defined: drop_cnt is a 16-bit counter that saturates at 0xFFFF. It increments once per dropped push and clears on rst.
- BP_UPD_DROP_CNT_EN undefined: drop_cnt is tied to 0 and no counter logic is built. Drop behaviour is otherwise identical.

## Test plan
- Reset, then release, with PHT_DEPTH=7. Required: pht_we=1 for 128 consecutive cycles with addresses 0..127 in order and wdata=01. init_busy=1 throughout and 0 on cycle 129. pht_we=0 afterwards while idle.
- In RUN, push idx=5 taken with pht_rdata=01. Required: the next cycle shows pht_we=1, waddr=5, wdata=10. The following cycle pht_we=0.
- Saturation: taken with rdata=11 → wdata=11. Not-taken with rdata=00 → wdata=00. Not-taken with rdata=10 → wdata=01.
- During INIT, push 5 updates back-to-back with FIFO_DEPTH=4. Required: upd_ready falls after the 4th push and the 5th is dropped; drop_cnt=1 with macro, 0 without. After INIT, the 4 entries are written in push order over 4 consecutive cycles.
- Two taken pushes to idx=9 in consecutive cycles, with a bench PHT model starting at 01. Required: writes of 10, then 11.
- Fill the queue with 3 entries in RUN, then assert rst for one cycle before the 2nd pop. Required: no write of the 2nd or 3rd entries, init_busy=1, and the sweep restarts at address 0.
